seg_mmio_ctrl: RTL and testbench

SEG_MMIO_CTRL -- requirements
Module: seg_mmio_ctrl

---
 rtl/seg_pkg.sv | 42 ++++
 rtl/hex_seg7_dec.sv | 38 +++
 rtl/seg_mmio_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_seg_mmio_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// ============================================================================
// Module  : seg_pkg
// Brief   : Shared register map, CTRL bit positions and blank constants for
//           the 8-digit seven-segment MMIO scanner.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_CTRL   = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_BLINK_BIT = 1;
  localparam int CTRL_DEN_LSB   = 8;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [6:0] DISP_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_DATA   = 2'd1,
    SEL_CTRL   = 2'd2,
    SEL_STATUS = 2'd3
  } reg_sel_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hex_seg7_dec.sv
// ============================================================================
// Module  : hex_seg7_dec
// Brief   : Combinational hex digit to active-low gfedcba segment decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_seg7_dec (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (hex_i)
      4'h0: seg_o = 7'b100_0000;
      4'h1: seg_o = 7'b111_1001;
      4'h2: seg_o = 7'b010_0100;
      4'h3: seg_o = 7'b011_0000;
      4'h4: seg_o = 7'b001_1001;
      4'h5: seg_o = 7'b001_0010;
      4'h6: seg_o = 7'b000_0010;
      4'h7: seg_o = 7'b111_1000;
      4'h8: seg_o = 7'b000_0000;
      4'h9: seg_o = 7'b001_0000;
      4'hA: seg_o = 7'b000_1000;
      4'hB: seg_o = 7'b000_0011;
      4'hC: seg_o = 7'b100_0110;
      4'hD: seg_o = 7'b010_0001;
      4'hE: seg_o = 7'b000_0110;
      4'hF: seg_o = 7'b000_1110;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_mmio_ctrl.sv
// ============================================================================
// Module  : seg_mmio_ctrl
// Brief   : Memory-mapped 8-digit multiplexed seven-segment scanner with
//           DATA/CTRL/STATUS registers. Define SEG_BLINK_EN for frame blink.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_mmio_ctrl
  import seg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int          SCAN_DIV  = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        rd,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  input  logic [3:0]  mask,
  output logic [31:0] data_rd,
  output logic [6:0]  Display,
  output logic [7:0]  Seg
);

  localparam int            PW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [31:0]   data_q, data_d;
  logic          en_q, en_d;
  logic [7:0]    den_q, den_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   rd_q, rd_d;
  logic [7:0]    seg_p_q, seg_p_d, seg_q;
  logic [6:0]    disp_p_q, disp_p_d, disp_q;

  reg_sel_e    w_sel;
  logic        w_we;
  logic        w_tick;
  logic        w_lit;
  logic [31:0] w_ctrl_rd;
  logic [3:0]  w_nibble;
  logic [6:0]  w_hex_seg;

`ifdef SEG_BLINK_EN
  logic       blink_q, blink_d;
  logic [7:0] frame_q, frame_d;
`endif

  always_comb begin
    w_sel = SEL_NONE;
    if (cs && (addr[31:4] == BASE_ADDR[31:4])) begin
      case (addr[3:0])
        OFF_DATA:   w_sel = SEL_DATA;
        OFF_CTRL:   w_sel = SEL_CTRL;
        OFF_STATUS: w_sel = SEL_STATUS;
        default:    w_sel = SEL_NONE;
      endcase
    end
  end

  assign w_we   = cs && !rd;
  assign w_tick = en_q && (presc_q == PRESC_LAST);

  always_comb begin
    w_ctrl_rd                   = '0;
    w_ctrl_rd[CTRL_EN_BIT]      = en_q;
    w_ctrl_rd[CTRL_DEN_LSB +: 8] = den_q;
`ifdef SEG_BLINK_EN
    w_ctrl_rd[CTRL_BLINK_BIT]   = blink_q;
`else
    w_ctrl_rd[CTRL_BLINK_BIT]   = 1'b0;
`endif
  end

  assign w_nibble = data_q[{idx_q, 2'b00} +: 4];

  hex_seg7_dec u_dec (
    .hex_i (w_nibble),
    .seg_o (w_hex_seg)
  );

`ifdef SEG_BLINK_EN
  assign w_lit = en_q && den_q[idx_q] && !(blink_q && frame_q[7]);
`else
  assign w_lit = en_q && den_q[idx_q];
`endif

  always_comb begin
    data_d  = data_q;
    en_d    = en_q;
    den_d   = den_q;
    presc_d = '0;
    idx_d   = idx_q;
    rd_d    = rd_q;
`ifdef SEG_BLINK_EN
    blink_d = blink_q;
    frame_d = frame_q;
`endif

    if (w_we && (w_sel == SEL_DATA)) begin
      data_d = byte_merge(data_q, data_wr, mask);
    end
    if (w_we && (w_sel == SEL_CTRL)) begin
      if (mask[CTRL_EN_BIT/8]) begin
        en_d = data_wr[CTRL_EN_BIT];
`ifdef SEG_BLINK_EN
        blink_d = data_wr[CTRL_BLINK_BIT];
`endif
      end
      if (mask[CTRL_DEN_LSB/8]) den_d = data_wr[CTRL_DEN_LSB +: 8];
    end

    if (en_q) begin
      presc_d = w_tick ? '0 : presc_q + PW'(1);
    end
    if (w_tick) begin
      idx_d = idx_q + 3'd1;
`ifdef SEG_BLINK_EN
      if (idx_q == 3'd7) frame_d = frame_q + 8'd1;
`endif
    end

    // Reads see the pre-write register state of this edge.
    if (cs && rd) begin
      case (w_sel)
        SEL_DATA:   rd_d = data_q;
        SEL_CTRL:   rd_d = w_ctrl_rd;
        SEL_STATUS: rd_d = {29'd0, idx_q};
        default:    rd_d = '0;
      endcase
    end

    seg_p_d  = w_lit ? ~(8'd1 << idx_q) : SEG_BLANK;
    disp_p_d = w_lit ? w_hex_seg : DISP_BLANK;
  end

  // Two output stages give a fixed two-cycle latency from any state change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q   <= '0;
      en_q     <= 1'b0;
      den_q    <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
      rd_q     <= '0;
      seg_p_q  <= SEG_BLANK;
      disp_p_q <= DISP_BLANK;
      seg_q    <= SEG_BLANK;
      disp_q   <= DISP_BLANK;
    end else begin
      data_q   <= data_d;
      en_q     <= en_d;
      den_q    <= den_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      rd_q     <= rd_d;
      seg_p_q  <= seg_p_d;
      disp_p_q <= disp_p_d;
      seg_q    <= seg_p_q;
      disp_q   <= disp_p_q;
    end
  end

`ifdef SEG_BLINK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_q <= 1'b0;
      frame_q <= '0;
    end else begin
      blink_q <= blink_d;
      frame_q <= frame_d;
    end
  end
`endif

  assign data_rd = rd_q;
  assign Seg     = seg_q;
  assign Display = disp_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_mmio_ctrl.sv
// ============================================================================
// Module  : tb_seg_mmio_ctrl
// Brief   : Self-checking bench for seg_mmio_ctrl: slot-count model plus
//           directed bus vectors with literal expectations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_mmio_ctrl;

  localparam int          DIV  = 4;
  localparam logic [31:0] BASE = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_wr = '0;
  logic [3:0]  mask = '0;
  logic [31:0] data_rd;
  logic [6:0]  Display;
  logic [7:0]  Seg;

  seg_mmio_ctrl #(.BASE_ADDR(BASE), .SCAN_DIV(DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .cs      (cs),
    .rd      (rd),
    .addr    (addr),
    .data_wr (data_wr),
    .mask    (mask),
    .data_rd (data_rd),
    .Display (Display),
    .Seg     (Seg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] LIT_DIGIT [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  // Model: architectural registers plus a count of elapsed slots since reset.
  logic [31:0] m_data = '0;
  bit          m_en = 1'b0;
  bit          m_blink = 1'b0;
  logic [7:0]  m_den = '0;
  int          m_run = 0;
  int          m_slots = 0;
  logic [31:0] m_rd = '0;
  logic [14:0] h0 = 15'h7FFF, h1 = 15'h7FFF, h2 = 15'h7FFF;

  function automatic logic [14:0] model_out();
    int  idx;
    int  frame;
    bit  lit;
    logic [7:0] s;
    idx   = m_slots % 8;
    frame = (m_slots / 8) % 256;
    lit   = m_en && m_den[idx] && !(m_blink && frame >= 128);
    s     = ~(8'd1 << idx);
    return lit ? {s, HEX[m_data[idx*4 +: 4]]} : 15'h7FFF;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_data = '0; m_en = 0; m_blink = 0; m_den = '0;
        m_run = 0; m_slots = 0; m_rd = '0;
        h0 = 15'h7FFF; h1 = 15'h7FFF; h2 = 15'h7FFF;
      end else begin
        if (cs && rd) begin
          m_rd = '0;
          if (addr[31:4] == BASE[31:4]) begin
            case (addr[3:0])
              4'h0: m_rd = m_data;
              4'h4: m_rd = {16'd0, m_den, 6'd0, m_blink, m_en};
              4'h8: m_rd = 32'(m_slots % 8);
              default: m_rd = '0;
            endcase
          end
        end
        if (m_en) begin
          m_run++;
          if (m_run == DIV) begin m_run = 0; m_slots++; end
        end else begin
          m_run = 0;
        end
        if (cs && !rd && addr[31:4] == BASE[31:4]) begin
          if (addr[3:0] == 4'h0) begin
            for (int b = 0; b < 4; b++)
              if (mask[b]) m_data[8*b +: 8] = data_wr[8*b +: 8];
          end else if (addr[3:0] == 4'h4) begin
            if (mask[0]) begin
              m_en = data_wr[0];
`ifdef SEG_BLINK_EN
              m_blink = data_wr[1];
`endif
            end
            if (mask[1]) m_den = data_wr[15:8];
          end
        end
        h2 = h1; h1 = h0; h0 = model_out();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        check("model_seg", {24'd0, Seg}, {24'd0, h2[14:7]});
        check("model_display", {25'd0, Display}, {25'd0, h2[6:0]});
        check("model_data_rd", data_rd, m_rd);
      end
    end
  end

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    cs = 1'b1; rd = 1'b0; addr = a; data_wr = d; mask = m;
    @(posedge clk); #1;
    cs = 1'b0; mask = 4'h0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
    d = data_rd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    logic [7:0]  s_exp;
    bit          found;
    int          n_fe, n_fb, n_ff;

    repeat (3) @(posedge clk);
    #1;
    check("reset_seg", {24'd0, Seg}, 32'h0000_00FF);
    check("reset_display", {25'd0, Display}, 32'h0000_007F);
    check("reset_data_rd", data_rd, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Byte-lane masked writes
    bus_wr(BASE, 32'h0, 4'hF);
    bus_wr(BASE, 32'hAAAA_AAAA, 4'b0010);
    bus_rd(BASE, v);
    check("mask_lane1", v, 32'h0000_AA00);
    bus_wr(BASE, 32'h1234_5678, 4'b0000);
    bus_rd(BASE, v);
    check("mask_none", v, 32'h0000_AA00);

    // Full scan with all digits enabled
    bus_wr(BASE, 32'h7654_3210, 4'hF);
    bus_wr(BASE + 32'h4, 32'h0000_FF01, 4'hF);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (Seg == 8'hFE) found = 1;
    end
    check("scan_start", {31'd0, found}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) repeat (DIV) @(negedge clk);
      s_exp = ~(8'd1 << (i % 8));
      check("scan_seg", {24'd0, Seg}, {24'd0, s_exp});
      check("scan_display", {25'd0, Display}, {25'd0, LIT_DIGIT[i % 8]});
    end

    // CTRL blink bit
    bus_wr(BASE + 32'h4, 32'h0000_FF03, 4'hF);
    bus_rd(BASE + 32'h4, v);
`ifdef SEG_BLINK_EN
    check("ctrl_blink_bit", v, 32'h0000_FF03);
`else
    check("ctrl_blink_bit", v, 32'h0000_FF01);
`endif
    bus_wr(BASE + 32'h4, 32'h0000_FF01, 4'hF);

    // STATUS write and misses change nothing; miss read returns 0
    bus_wr(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF);
    bus_wr(BASE + 32'h10, 32'h0, 4'hF);
    bus_wr(BASE + 32'hC, 32'h0, 4'hF);
    bus_rd(BASE, v);
    check("miss_data_kept", v, 32'h7654_3210);
    bus_rd(BASE + 32'h4, v);
    check("miss_ctrl_kept", v, 32'h0000_FF01);
    bus_rd(BASE + 32'h10, v);
    check("miss_read_zero", v, 32'h0);

    // Asynchronous reset mid-scan
    bus_rd(BASE, v);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("async_rst_seg", {24'd0, Seg}, 32'h0000_00FF);
    check("async_rst_display", {25'd0, Display}, 32'h0000_007F);
    check("async_rst_data_rd", data_rd, 32'h0);
    @(posedge clk); #1 reset = 1'b1;
    bus_rd(BASE + 32'h8, v);
    check("post_rst_status", v, 32'h0);
    bus_rd(BASE, v);
    check("post_rst_data", v, 32'h0);

    // Sparse digit enables: only slots 0 and 2 lit
    bus_wr(BASE, 32'h7654_3210, 4'hF);
    bus_wr(BASE + 32'h4, 32'h0000_0501, 4'hF);
    repeat (4) @(posedge clk);
    #1;
    bus_rd(BASE + 32'h8, v);
    check("sparse_status_1", v, 32'd1);
    repeat (7) @(posedge clk);
    #1;
    bus_rd(BASE + 32'h8, v);
    check("sparse_status_3", v, 32'd3);
    n_fe = 0; n_fb = 0; n_ff = 0;
    for (int k = 0; k < 8 * DIV; k++) begin
      @(negedge clk);
      if (Seg == 8'hFE) n_fe++;
      else if (Seg == 8'hFB) n_fb++;
      else if (Seg == 8'hFF) n_ff++;
    end
    check("sparse_slot0_cycles", 32'(n_fe), 32'd4);
    check("sparse_slot2_cycles", 32'(n_fb), 32'd4);
    check("sparse_blank_cycles", 32'(n_ff), 32'd24);

`ifdef SEG_BLINK_EN
    // Blink across frame 128 boundary
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    bus_wr(BASE + 32'h4, 32'h0000_FF03, 4'hF);
    repeat (100 * 8 * DIV) @(posedge clk);
    #1;
    check("blink_lit_frame100", {31'd0, (Seg != 8'hFF)}, 32'd1);
    repeat (40 * 8 * DIV) @(posedge clk);
    #1;
    check("blink_dark_frame140", {24'd0, Seg}, 32'h0000_00FF);
`endif

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
